// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the 8 KB byte-wide program memory
// and the instruction decoder. Reads one- and two-byte instructions, packs
// them into a 16-bit word and offers each one over a valid/ready handshake.
// Jumps (redirect) and loss of the memory port (mem_grant=0) are honoured
// every cycle.
//
// Optional feature: define IFETCH_PREFETCH_EN to add a one-byte prefetch
// buffer that is filled while an instruction waits in HOLD. Without the
// macro, HOLD never touches memory.
module instruction_fetch #(
    parameter logic [12:0] RESET_PC = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [12:0] address,
    output logic        mem_read,
    input  logic [7:0]  command,
    input  logic        mem_grant,
    input  logic        redirect,
    input  logic [12:0] redirect_addr,
    output logic [15:0] instr,
    output logic        instr_two,
    output logic [12:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [12:0] pc_q;
    logic [15:0] instr_q;
    logic        instr_two_q;
    logic [12:0] instr_pc_q;
    logic        instr_valid_q;

    // Handshake completes this edge.
    logic        accept;
    // A first instruction byte is available and gets captured this edge.
    logic        first_go;
    logic [7:0]  first_byte;
    logic [12:0] first_pc;

`ifdef IFETCH_PREFETCH_EN
    logic        buf_full_q;
    logic [7:0]  buf_q;
`endif

    // LDA/STA/ADA... (b[7]=0) and JMP (b[7:5]=110) carry an operand byte.
    function automatic logic is_two_byte(input logic [7:0] b);
        return (b[7] == 1'b0) || (b[7:5] == 3'b110);
    endfunction

    assign accept = instr_valid_q && instr_ready;

    // Decide whether memory is read this cycle and where the first byte comes from.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        mem_read   = 1'b0;
        first_go   = 1'b0;
        first_byte = command;
        first_pc   = pc_q;
`ifdef IFETCH_PREFETCH_EN
        // BYTE1 always starts with an empty buffer, so the buffer flag alone
        // decides whether a read is needed in any state.
        mem_read = rst && !redirect && mem_grant && !buf_full_q;
        if (buf_full_q) begin
            first_byte = buf_q;
            first_pc   = pc_q - 13'd1;
        end
        first_go = ((state_q == BYTE0) || ((state_q == HOLD) && accept))
                   && (buf_full_q || mem_grant);
`else
        mem_read = rst && !redirect && mem_grant && (state_q != HOLD);
        first_go = (state_q == BYTE0) && mem_grant;
`endif
    end

    // Fetch state machine: reset, then redirect, then normal byte assembly.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register here sees the
        // pre-edge value of every other register regardless of statement order.
        if (!rst) begin
            state_q       <= BYTE0;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_two_q   <= 1'b0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            buf_full_q    <= 1'b0;
            buf_q         <= '0;
`endif
        end else if (redirect) begin
            // Any partial instruction and any coincident acceptance are dropped.
            state_q       <= BYTE0;
            pc_q          <= redirect_addr;
            instr_valid_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            buf_full_q    <= 1'b0;
`endif
        end else begin
            // Every memory read consumes one byte address, wrapping at 8 KB.
            if (mem_read) begin
                pc_q <= pc_q + 13'd1;
            end

            if (first_go) begin
                instr_q     <= {first_byte, 8'h00};
                instr_pc_q  <= first_pc;
                instr_two_q <= 1'b0;
                if (is_two_byte(first_byte)) begin
                    instr_valid_q <= 1'b0;
                    state_q       <= BYTE1;
                end else begin
                    instr_valid_q <= 1'b1;
                    state_q       <= HOLD;
                end
            end else begin
                case (state_q)
                    BYTE1: begin
                        if (mem_grant) begin
                            instr_q[7:0]  <= command;
                            instr_two_q   <= 1'b1;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            instr_valid_q <= 1'b0;
                            state_q       <= BYTE0;
                        end
                    end
                    default: begin
                    end
                endcase
            end

`ifdef IFETCH_PREFETCH_EN
            // The buffer empties whenever a first byte is taken; otherwise a
            // read in HOLD parks its byte here.
            if (first_go) begin
                buf_full_q <= 1'b0;
            end else if ((state_q == HOLD) && mem_read) begin
                buf_q      <= command;
                buf_full_q <= 1'b1;
            end
`endif
        end
    end

    assign address     = pc_q;
    assign instr       = instr_q;
    assign instr_two   = instr_two_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch (default build, no prefetch).
// The reference model collects fetched bytes in a queue and releases a
// complete instruction once the first byte's length rule is satisfied.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [12:0] address;
    logic        mem_read;
    logic [7:0]  command;
    logic        mem_grant;
    logic        redirect;
    logic [12:0] redirect_addr;
    logic [15:0] instr;
    logic        instr_two;
    logic [12:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [7:0]  mem [0:8191];

    int n_vec;
    int n_err;

    // Reference model state.
    logic [12:0] m_pc;
    logic [7:0]  m_q[$];
    logic [12:0] m_start;
    logic        m_have;
    logic [15:0] m_instr;
    logic        m_two;
    logic [12:0] m_ipc;
    logic        mr_seen;

    instruction_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .mem_read      (mem_read),
        .command       (command),
        .mem_grant     (mem_grant),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr         (instr),
        .instr_two     (instr_two),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready)
    );

    assign command = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ilen(input logic [7:0] b);
        return ((b[7] == 1'b0) || (b[7:5] == 3'b110)) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_pc   = 13'h0000;
        m_q.delete();
        m_have = 1'b0;
    endtask

    // Advance the model across one clock edge given that cycle's inputs.
    task automatic model_edge(input logic r, input logic g, input logic rd,
                              input logic [12:0] ra, input logic rdy);
        if (!r) begin
            model_reset();
        end else if (rd) begin
            m_pc = ra;
            m_q.delete();
            m_have = 1'b0;
        end else if (m_have) begin
            if (rdy) m_have = 1'b0;
        end else if (g) begin
            if (m_q.size() == 0) m_start = m_pc;
            m_q.push_back(mem[m_pc]);
            m_pc = m_pc + 13'd1;
            if (m_q.size() == ilen(m_q[0])) begin
                m_have  = 1'b1;
                m_two   = (m_q.size() == 2);
                m_instr = {m_q[0], m_two ? m_q[1] : 8'h00};
                m_ipc   = m_start;
                m_q.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then clock it.
    task automatic step(input logic r, input logic g, input logic rd,
                        input logic [12:0] ra, input logic rdy);
        rst           = r;
        mem_grant     = g;
        redirect      = rd;
        redirect_addr = ra;
        instr_ready   = rdy;
        #1;
        mr_seen = mem_read;
        check("address", 16'(address), 16'(m_pc));
        check("mem_read", 16'(mem_read), 16'(r && g && !rd && !m_have));
        check("instr_valid", 16'(instr_valid), 16'(m_have));
        if (m_have) begin
            check("instr", instr, m_instr);
            check("instr_two", 16'(instr_two), 16'(m_two));
            check("instr_pc", 16'(instr_pc), 16'(m_ipc));
        end
        @(posedge clk);
        model_edge(r, g, rd, ra, rdy);
        #1;
    endtask

    initial begin
        int reads;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'hE0;
        mem[0] = 8'hE1;
        mem[1] = 8'h00;
        mem[2] = 8'h7F;
        mem[3] = 8'h12;
        mem[10] = 8'hE5;

        rst = 1'b0; mem_grant = 1'b1; redirect = 1'b0;
        redirect_addr = '0; instr_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state.
        check("rst_valid", 16'(instr_valid), 16'h0);
        check("rst_instr", instr, 16'h0000);
        check("rst_two", 16'(instr_two), 16'h0);
        check("rst_pc", 16'(instr_pc), 16'h0);
        check("rst_addr", 16'(address), 16'h0);
        check("rst_mem_read", 16'(mem_read), 16'h0);

        // First instructions after release.
        step(1, 1, 0, 0, 1);
        check("c1_valid", 16'(instr_valid), 16'h1);
        check("c1_instr", instr, 16'hE100);
        check("c1_two", 16'(instr_two), 16'h0);
        check("c1_pc", 16'(instr_pc), 16'h0);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        check("b1_addr", 16'(address), 16'h2);
        step(1, 1, 0, 0, 1);
        check("i2_valid", 16'(instr_valid), 16'h1);
        check("i2_instr", instr, 16'h007F);
        check("i2_two", 16'(instr_two), 16'h1);
        check("i2_pc", 16'(instr_pc), 16'h1);

        // Backpressure.
        reads = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 0);
            reads += int'(mr_seen);
            check("bp_instr", instr, 16'h007F);
            check("bp_pc", 16'(instr_pc), 16'h1);
            check("bp_valid", 16'(instr_valid), 16'h1);
        end
        check("bp_reads", 16'(reads), 16'h0);
        step(1, 1, 0, 0, 1);
        check("bp_accept_once", 16'(instr_valid), 16'h0);
        check("bp_next_addr", 16'(address), 16'h3);

        // Redirect during BYTE1.
        step(1, 1, 0, 0, 1);
        check("rd_pre_addr", 16'(address), 16'h4);
        step(1, 1, 1, 13'h000A, 1);
        check("rd_valid", 16'(instr_valid), 16'h0);
        check("rd_addr", 16'(address), 16'h000A);
        step(1, 1, 0, 0, 0);
        check("rd_first_valid", 16'(instr_valid), 16'h1);
        check("rd_first_instr", instr, 16'hE500);
        check("rd_first_pc", 16'(instr_pc), 16'h000A);
        step(1, 1, 0, 0, 1);

        // Wrap between the two bytes of one instruction.
        mem[8191] = 8'hC0;
        mem[0]    = 8'h0A;
        mem[1]    = 8'h20;
        mem[2]    = 8'h5A;
        step(1, 1, 1, 13'h1FFF, 1);
        check("wr_addr", 16'(address), 16'h1FFF);
        step(1, 1, 0, 0, 1);
        check("wr_addr0", 16'(address), 16'h0000);
        step(1, 1, 0, 0, 0);
        check("wr_instr", instr, 16'hC00A);
        check("wr_two", 16'(instr_two), 16'h1);
        check("wr_pc", 16'(instr_pc), 16'h1FFF);
        check("wr_next_addr", 16'(address), 16'h0001);
        step(1, 1, 0, 0, 1);

        // Grant stall in BYTE1.
        step(1, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1);
            check("gs_addr", 16'(address), 16'h2);
            check("gs_valid", 16'(instr_valid), 16'h0);
        end
        check("gs_mem_read", 16'(mr_seen), 16'h0);
        step(1, 1, 0, 0, 0);
        check("gs_valid_done", 16'(instr_valid), 16'h1);
        check("gs_instr", instr, 16'h205A);
        check("gs_pc", 16'(instr_pc), 16'h1);
        step(1, 1, 0, 0, 1);

        // Reset mid-BYTE1, then refetch from the reset address.
        step(1, 1, 0, 0, 1);
        check("mr_pre_addr", 16'(address), 16'h4);
        step(0, 1, 0, 0, 1);
        check("mr_valid", 16'(instr_valid), 16'h0);
        check("mr_addr", 16'(address), 16'h0);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        check("mr_instr", instr, 16'h0A20);
        check("mr_pc", 16'(instr_pc), 16'h0);
        check("mr_refetch_valid", 16'(instr_valid), 16'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        for (int c = 0; c < 4000; c++) begin
            logic        r, g, rd, rdy;
            logic [12:0] ra;
            r   = ($urandom_range(0, 59) != 0);
            g   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            ra  = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(8186, 8191))
                                              : 13'($urandom);
            step(r, g, rd, ra, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
